// File: rtl/cache_controller.sv
// Two-way set-associative, write-through / no-write-allocate cache controller.
// Reads hit with zero added latency; misses fill a 64-bit block from the SRAM controller.
module cache_controller #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;

  state_e state_q, state_d;

  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [63:0]          data_q [2][SETS];

  logic [INDEX_W-1:0] index_s;
  logic [TAG_W-1:0]   tag_s;
  logic               word_sel_s;
  logic               hit0_s, hit1_s, hit_s, hit_way_s, victim_s;
  logic [63:0]        hit_line_s;
  logic [31:0]        hit_word_s;
  logic               fill_s, wr_hit_s, lru_we_s, lru_val_s;

  assign index_s    = address[INDEX_W+2:3];
  assign tag_s      = address[INDEX_W+3+TAG_W-1:INDEX_W+3];
  assign word_sel_s = address[2];

  assign hit0_s     = valid_q[0][index_s] && (tag_q[0][index_s] == tag_s);
  assign hit1_s     = valid_q[1][index_s] && (tag_q[1][index_s] == tag_s);
  assign hit_s      = hit0_s || hit1_s;
  assign hit_way_s  = hit1_s;
  assign hit_line_s = hit1_s ? data_q[1][index_s] : data_q[0][index_s];
  assign hit_word_s = word_sel_s ? hit_line_s[63:32] : hit_line_s[31:0];

  // LRU bit names the way to evict once both ways are valid
  assign victim_s = !valid_q[0][index_s] ? 1'b0 :
                    !valid_q[1][index_s] ? 1'b1 : lru_q[index_s];

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    ready        = 1'b0;
    rdata        = 32'h0000_0000;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = 32'h0000_0000;
    sram_wdata   = 32'h0000_0000;
    fill_s       = 1'b0;
    wr_hit_s     = 1'b0;
    lru_we_s     = 1'b0;
    lru_val_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          state_d = WR_THRU;
          if (hit_s) begin
            wr_hit_s  = 1'b1;
            lru_we_s  = 1'b1;
            lru_val_s = ~hit_way_s;
          end else begin
            wr_hit_s  = 1'b0;
          end
        end else if (MEM_R_EN) begin
          if (hit_s) begin
            ready     = 1'b1;
            rdata     = hit_word_s;
            lru_we_s  = 1'b1;
            lru_val_s = ~hit_way_s;
          end else begin
            state_d = RD_MISS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_MISS: begin
        sram_rd_en   = 1'b1;
        sram_address = {address[31:3], 3'b000};
        if (sram_ready) begin
          ready     = 1'b1;
          rdata     = word_sel_s ? sram_rdata[63:32] : sram_rdata[31:0];
          fill_s    = 1'b1;
          lru_we_s  = 1'b1;
          lru_val_s = ~victim_s;
          state_d   = IDLE;
        end else begin
          state_d = RD_MISS;
        end
      end
      WR_THRU: begin
        sram_wr_en   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WR_THRU;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid and LRU bits; only these gate hits, so only these are reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (fill_s) begin
        valid_q[victim_s][index_s] <= 1'b1;
      end
      if (lru_we_s) begin
        lru_q[index_s] <= lru_val_s;
      end
    end
  end

  // Tag and data arrays: line fill on read miss, word update on write hit
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_q[victim_s][index_s]  <= tag_s;
      data_q[victim_s][index_s] <= sram_rdata;
    end
    if (wr_hit_s) begin
      if (word_sel_s) begin
        data_q[hit_way_s][index_s][63:32] <= wdata;
      end else begin
        data_q[hit_way_s][index_s][31:0]  <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed vector table, hand-written
// reset/protocol corner cases, then random traffic against a recency-list cache model.
module tb_cache_controller;

  logic        clk;
  logic        rst_n;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready, sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int total = 0;
  int bad   = 0;

  cache_controller #(.INDEX_W(6), .TAG_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_RD, OP_WR, OP_BOTH, OP_RST} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  // Reference model: backing memory plus per-set recency lists (front = most recent)
  logic [63:0] mem [logic [28:0]];
  logic [9:0]  rec [64][$];

  function automatic logic [63:0] get_blk(input logic [28:0] b);
    if (mem.exists(b)) return mem[b];
    return {b, 3'b101, ~b, 3'b010};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    foreach (rec[a[8:3]][k]) if (rec[a[8:3]][k] == a[18:9]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_touch(input logic [31:0] a);
    for (int k = 0; k < rec[a[8:3]].size(); k++)
      if (rec[a[8:3]][k] == a[18:9]) begin
        rec[a[8:3]].delete(k);
        break;
      end
    if (rec[a[8:3]].size() == 2) void'(rec[a[8:3]].pop_back());
    rec[a[8:3]].push_front(a[18:9]);
  endtask

  task automatic m_update(input op_e op, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] blk;
    if (op == OP_RD) begin
      m_touch(a);
    end else begin
      if (m_hit(a)) m_touch(a);
      blk = get_blk(a[31:3]);
      if (a[2]) blk[63:32] = d; else blk[31:0] = d;
      mem[a[31:3]] = blk;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s addr=%h got=%h want=%h", nm, address, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ready"}, ready, 1'b0);
    chk({nm, "_rdata"}, rdata, 32'h0);
    chk({nm, "_rd_en"}, sram_rd_en, 1'b0);
    chk({nm, "_wr_en"}, sram_wr_en, 1'b0);
    chk({nm, "_saddr"}, sram_address, 32'h0);
    chk({nm, "_swdata"}, sram_wdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    #1 chk_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 64; s++) rec[s].delete();
  endtask

  task automatic do_access(input op_e op, input logic [31:0] a, input logic [31:0] d,
                           input bit exp_hit, input logic [31:0] exp_rd);
    int lat;
    lat = $urandom_range(0, 2);
    @(negedge clk);
    address = a; wdata = d;
    MEM_W_EN = (op != OP_RD);
    MEM_R_EN = (op != OP_WR);
    #1;
    chk("idle_rd_en", sram_rd_en, 1'b0);
    chk("idle_wr_en", sram_wr_en, 1'b0);
    if (op == OP_RD) begin
      chk("rd_hit_ready", ready, exp_hit);
      if (exp_hit) chk("rd_hit_data", rdata, exp_rd);
      @(posedge clk);
      if (!exp_hit) begin
        for (int i = 0; i < lat; i++) begin
          @(negedge clk); #1;
          chk("miss_rd_en", sram_rd_en, 1'b1);
          chk("miss_saddr", sram_address, {a[31:3], 3'b000});
          chk("miss_wait_ready", ready, 1'b0);
          @(posedge clk);
        end
        @(negedge clk);
        sram_ready = 1'b1; sram_rdata = get_blk(a[31:3]);
        #1;
        chk("miss_rd_en_last", sram_rd_en, 1'b1);
        chk("miss_wr_en", sram_wr_en, 1'b0);
        chk("miss_ready", ready, 1'b1);
        chk("miss_data", rdata, exp_rd);
        @(posedge clk);
      end
    end else begin
      chk("wr_idle_ready", ready, 1'b0);
      @(posedge clk);
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        if (i == lat) sram_ready = 1'b1;
        #1;
        chk("wr_wr_en", sram_wr_en, 1'b1);
        chk("wr_rd_en", sram_rd_en, 1'b0);
        chk("wr_saddr", sram_address, a);
        chk("wr_swdata", sram_wdata, d);
        chk("wr_ready", ready, (i == lat));
        @(posedge clk);
      end
    end
    @(negedge clk);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    #1 chk_quiet("after");
  endtask

  vec_t tbl [15];
  logic [31:0] ra, rd;
  op_e         rop;

  initial begin
    rst_n = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = 32'h0; wdata = 32'h0;
    sram_rdata = 64'h0; sram_ready = 1'b0;
    mem[29'h0]   = 64'h1111_2222_3333_4444;
    mem[29'h40]  = 64'h5555_6666_7777_8888;
    mem[29'h80]  = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[29'h1000] = 64'h9999_0000_DEAD_BEEF;

    tbl[0]  = '{OP_RST,  32'h0000_0000, 32'h0,          1'b0, 32'h0};
    tbl[1]  = '{OP_RD,   32'h0000_0000, 32'h0,          1'b0, 32'h3333_4444};
    tbl[2]  = '{OP_RD,   32'h0000_0200, 32'h0,          1'b0, 32'h7777_8888};
    tbl[3]  = '{OP_RD,   32'h0000_0400, 32'h0,          1'b0, 32'hCCCC_DDDD};
    tbl[4]  = '{OP_RD,   32'h0000_0200, 32'h0,          1'b1, 32'h7777_8888};
    tbl[5]  = '{OP_RD,   32'h0000_0000, 32'h0,          1'b0, 32'h3333_4444};
    tbl[6]  = '{OP_RST,  32'h0000_0000, 32'h0,          1'b0, 32'h0};
    tbl[7]  = '{OP_RD,   32'h0000_0404, 32'h0,          1'b0, 32'hAAAA_BBBB};
    tbl[8]  = '{OP_RD,   32'h0000_0404, 32'h0,          1'b1, 32'hAAAA_BBBB};
    tbl[9]  = '{OP_WR,   32'h0000_0400, 32'h1234_5678,  1'b1, 32'h0};
    tbl[10] = '{OP_RD,   32'h0000_0400, 32'h0,          1'b1, 32'h1234_5678};
    tbl[11] = '{OP_WR,   32'h0000_8000, 32'hCAFE_F00D,  1'b0, 32'h0};
    tbl[12] = '{OP_RD,   32'h0000_8000, 32'h0,          1'b0, 32'hCAFE_F00D};
    tbl[13] = '{OP_BOTH, 32'h0000_0404, 32'h0BAD_CAFE,  1'b1, 32'h0};
    tbl[14] = '{OP_RD,   32'h0000_0404, 32'h0,          1'b1, 32'h0BAD_CAFE};

    #1 chk_quiet("por");
    foreach (tbl[i]) begin
      if (tbl[i].op == OP_RST) do_reset();
      else begin
        do_access(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].exp_hit, tbl[i].exp_rd);
        m_update(tbl[i].op, tbl[i].addr, tbl[i].data);
      end
    end

    // sram_ready while idle must be ignored
    @(negedge clk);
    sram_ready = 1'b1; sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 chk_quiet("idle_sready");
    @(negedge clk);
    sram_ready = 1'b0;
    do_access(OP_RD, 32'h0000_0404, 32'h0, 1'b1, 32'h0BAD_CAFE);

    // reset asserted in the middle of a read miss
    do_reset();
    @(negedge clk);
    MEM_R_EN = 1'b1; address = 32'h0000_0404;
    @(negedge clk); #1;
    chk("rmiss_rd_en", sram_rd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_quiet("rst_in_rdmiss");
    @(negedge clk);
    MEM_R_EN = 1'b0; rst_n = 1'b1;
    do_access(OP_RD, 32'h0000_0404, 32'h0, 1'b0, get_blk(29'h80) >> 32);
    m_update(OP_RD, 32'h0000_0404, 32'h0);

    // reset asserted in the middle of a write-through
    @(negedge clk);
    MEM_W_EN = 1'b1; address = 32'h0000_0404; wdata = 32'h5A5A_5A5A;
    @(negedge clk); #1;
    chk("wthru_wr_en", sram_wr_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_quiet("rst_in_wrthru");
    @(negedge clk);
    MEM_W_EN = 1'b0; rst_n = 1'b1;
    for (int s = 0; s < 64; s++) rec[s].delete();
    do_access(OP_RD, 32'h0000_0404, 32'h0, 1'b0, get_blk(29'h80) >> 32);
    m_update(OP_RD, 32'h0000_0404, 32'h0);

    // request dropped during a read miss: the SRAM transaction still completes
    @(negedge clk);
    MEM_R_EN = 1'b1; address = 32'h0000_2000;
    @(negedge clk);
    MEM_R_EN = 1'b0;
    #1 chk("drop_rd_en_held", sram_rd_en, 1'b1);
    @(negedge clk);
    #1 chk("drop_rd_en_held2", sram_rd_en, 1'b1);
    sram_ready = 1'b1; sram_rdata = get_blk(29'h400);
    #1 chk("drop_ready", ready, 1'b1);
    @(negedge clk);
    sram_ready = 1'b0;
    #1 chk_quiet("drop_back_idle");
    do_reset();

    // random traffic over a few sets and tags to exercise conflicts and LRU
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 1) << 3) | ($urandom_range(0, 1) << 2);
      rd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rop = OP_RD;
        6, 7, 8:          rop = OP_WR;
        default:          rop = OP_BOTH;
      endcase
      do_access(rop, ra, rd, m_hit(ra),
                ra[2] ? get_blk(ra[31:3]) >> 32 : get_blk(ra[31:3]) & 64'hFFFF_FFFF);
      m_update(rop, ra, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
